// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares one backing-memory port between two cache controllers.
//               Requester 0 is the instruction cache and requester 1 is the
//               data cache. A granted access holds the memory strobe for
//               MEM_LATENCY cycles. Read data is captured on the last access
//               cycle, and a one-cycle done pulse then goes to the granted
//               requester. Every output is registered.
// Revision    : 1.0 - initial release
//
// Parameters  : ADDR_SIZE   - address width
//               DATA_SIZE   - data width
//               MEM_LATENCY - memory cycles per access (1..255)
// Build macro : ARB_FIXED_PRIORITY_EN - when defined, requester 0 always wins
//               simultaneous requests. The default build uses round robin.
//
// Ports       : clk, reset (async, active-high)
//               req{0,1}Read/Write   - request levels, held until done{0,1}
//               req{0,1}Address/WData- request address / write data
//               req{0,1}RData        - last read data returned to requester
//               done{0,1}            - one-cycle completion pulse
//               memRead/memWrite     - memory strobes
//               memAddress/memWData  - memory address / write data
//               memRData             - memory read data (valid in last cycle)
// ============================================================================
module cache_mem_arbiter #(
  parameter int ADDR_SIZE   = 16,
  parameter int DATA_SIZE   = 16,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0Read,
  input  logic                 req0Write,
  input  logic [ADDR_SIZE-1:0] req0Address,
  input  logic [DATA_SIZE-1:0] req0WData,
  output logic [DATA_SIZE-1:0] req0RData,
  output logic                 done0,
  input  logic                 req1Read,
  input  logic                 req1Write,
  input  logic [ADDR_SIZE-1:0] req1Address,
  input  logic [DATA_SIZE-1:0] req1WData,
  output logic [DATA_SIZE-1:0] req1RData,
  output logic                 done1,
  output logic                 memRead,
  output logic                 memWrite,
  output logic [ADDR_SIZE-1:0] memAddress,
  output logic [DATA_SIZE-1:0] memWData,
  input  logic [DATA_SIZE-1:0] memRData
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // The counter is loaded with the number of edges still to wait after the
  // granting edge, so the access is finished when it reads zero.
  localparam logic [7:0] LAT_LAST = 8'(MEM_LATENCY - 1);

  state_t               state, state_nxt;
  logic [7:0]           count, count_nxt;
  logic                 grant_id, grant_id_nxt;
  logic                 mem_read_nxt, mem_write_nxt;
  logic [ADDR_SIZE-1:0] mem_addr_nxt;
  logic [DATA_SIZE-1:0] mem_wdata_nxt;
  logic [DATA_SIZE-1:0] rdata0_nxt, rdata1_nxt;
  logic                 done0_nxt, done1_nxt;

  logic req0, req1;
  logic pick;       // requester chosen if a grant happens this cycle
  logic pick_write; // a write wins when both strobes are high

  assign req0 = req0Read | req0Write;
  assign req1 = req1Read | req1Write;

`ifdef ARB_FIXED_PRIORITY_EN
  assign pick = ~req0;
`else
  logic last_grant, last_grant_nxt;
  // On a tie, favour whichever requester was not served last.
  assign pick = (req0 & req1) ? ~last_grant : req1;
`endif

  assign pick_write = pick ? req1Write : req0Write;

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    grant_id_nxt  = grant_id;
    mem_read_nxt  = memRead;
    mem_write_nxt = memWrite;
    mem_addr_nxt  = memAddress;
    mem_wdata_nxt = memWData;
    rdata0_nxt    = req0RData;
    rdata1_nxt    = req1RData;
    done0_nxt     = 1'b0;
    done1_nxt     = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
    last_grant_nxt = last_grant;
`endif

    case (state)
      ST_IDLE: begin
        if (req0 | req1) begin
          grant_id_nxt  = pick;
          mem_read_nxt  = ~pick_write;
          mem_write_nxt = pick_write;
          mem_addr_nxt  = pick ? req1Address : req0Address;
          mem_wdata_nxt = pick ? req1WData : req0WData;
          count_nxt     = LAT_LAST;
`ifndef ARB_FIXED_PRIORITY_EN
          last_grant_nxt = pick;
`endif
          state_nxt     = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (count == 8'd0) begin
          // memWrite still identifies the operation of this access.
          if (!memWrite) begin
            if (grant_id) rdata1_nxt = memRData;
            else          rdata0_nxt = memRData;
          end
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          done0_nxt     = ~grant_id;
          done1_nxt     = grant_id;
          state_nxt     = ST_DONE;
        end else begin
          count_nxt = count - 8'd1;
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= 8'd0;
      grant_id   <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_grant <= 1'b1;
`endif
      memRead    <= 1'b0;
      memWrite   <= 1'b0;
      memAddress <= '0;
      memWData   <= '0;
      req0RData  <= '0;
      req1RData  <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      grant_id   <= grant_id_nxt;
`ifndef ARB_FIXED_PRIORITY_EN
      last_grant <= last_grant_nxt;
`endif
      memRead    <= mem_read_nxt;
      memWrite   <= mem_write_nxt;
      memAddress <= mem_addr_nxt;
      memWData   <= mem_wdata_nxt;
      req0RData  <= rdata0_nxt;
      req1RData  <= rdata1_nxt;
      done0      <= done0_nxt;
      done1      <= done1_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Scoreboard bench for cache_mem_arbiter. The drivers queue the
//               expected transactions for each requester. A monitor predicts
//               grant order and access timing from the arbitration rules, and
//               compares the DUT outputs on every cycle. A second instance
//               with MEM_LATENCY=1 is exercised directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

  localparam int LAT     = 4;
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_read, req0_write, req1_read, req1_write;
  logic [15:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic [15:0] req0_rdata, req1_rdata;
  logic        done0, done1;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        b_req0_read;
  logic [15:0] b_req0_addr;
  logic [15:0] b_req0_rdata, b_req1_rdata;
  logic        b_done0, b_done1, b_mem_read, b_mem_write;
  logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_SIZE(16), .DATA_SIZE(16), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(rst),
    .req0Read(req0_read), .req0Write(req0_write), .req0Address(req0_addr),
    .req0WData(req0_wdata), .req0RData(req0_rdata), .done0(done0),
    .req1Read(req1_read), .req1Write(req1_write), .req1Address(req1_addr),
    .req1WData(req1_wdata), .req1RData(req1_rdata), .done1(done1),
    .memRead(mem_read), .memWrite(mem_write), .memAddress(mem_addr),
    .memWData(mem_wdata), .memRData(mem_rdata)
  );

  cache_mem_arbiter #(.ADDR_SIZE(16), .DATA_SIZE(16), .MEM_LATENCY(1)) dut_lat1 (
    .clk(clk), .reset(rst),
    .req0Read(b_req0_read), .req0Write(1'b0), .req0Address(b_req0_addr),
    .req0WData(16'h0000), .req0RData(b_req0_rdata), .done0(b_done0),
    .req1Read(1'b0), .req1Write(1'b0), .req1Address(16'h0000),
    .req1WData(16'h0000), .req1RData(b_req1_rdata), .done1(b_done1),
    .memRead(b_mem_read), .memWrite(b_mem_write), .memAddress(b_mem_addr),
    .memWData(b_mem_wdata), .memRData(b_mem_rdata)
  );

  // Memory contents: fixed function of the address, with 0x0040 holding 0xBEEF.
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    logic [31:0] p;
    if (a == 16'h0040) return 16'hBEEF;
    p = a * 32'h0000_9E37;
    return p[15:0] ^ 16'hA5C3;
  endfunction

  // Read data is valid only in the last access cycle and garbage before it.
  int rd_cnt = 0;
  always @(negedge clk) begin
    if (mem_read) rd_cnt <= rd_cnt + 1;
    else          rd_cnt <= 0;
  end
  assign mem_rdata   = (mem_read && rd_cnt == LAT) ? mem_val(mem_addr) : ~mem_val(mem_addr);
  assign b_mem_rdata = b_mem_read ? mem_val(b_mem_addr) : 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    bit          w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] rd;
  } txn_t;

  txn_t        q0[$];
  txn_t        q1[$];
  txn_t        act;
  bit          act_valid;
  int          act_id;
  int          cyc, g, next_free, model_last;
  bit          rec0, rec1;
  bit          granted0, granted1;
  logic [15:0] m_rd0, m_rd1;
  bit          mon_en = 1'b0;

  task automatic init_model();
    q0.delete(); q1.delete();
    act_valid = 0; act_id = 0;
    cyc = 0; g = 0; next_free = 1; model_last = 1;
    rec0 = 0; rec1 = 0; granted0 = 0; granted1 = 0;
    m_rd0 = 16'h0000; m_rd1 = 16'h0000;
  endtask

  function automatic int exp_grant(input bit r0, input bit r1);
`ifdef ARB_FIXED_PRIORITY_EN
    return r0 ? 0 : 1;
`else
    if (r0 && r1) return 1 - model_last;
    return r0 ? 0 : 1;
`endif
  endfunction

  // Monitor: runs in the middle of every cycle.
  initial begin
    bit exp_strobe, exp_done;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        // A request level seen during the previous cycle is taken at the edge
        // that starts this cycle, provided the arbiter has become idle again.
        if (!act_valid && cyc >= next_free && (rec0 || rec1)) begin
          act_id     = exp_grant(rec0, rec1);
          model_last = act_id;
          chk("grant_has_txn", (act_id == 0) ? q0.size() : q1.size(), 1);
          if ((act_id == 0 && q0.size() != 0) || (act_id == 1 && q1.size() != 0)) begin
            act       = (act_id == 0) ? q0[0] : q1[0];
            act_valid = 1;
            g         = cyc;
            next_free = cyc + LAT + 2;
            if (act_id == 0) granted0 = 1; else granted1 = 1;
          end
        end
        exp_strobe = act_valid && (cyc < g + LAT);
        exp_done   = act_valid && (cyc == g + LAT);
        chk("mem_read", mem_read, exp_strobe && !act.w);
        chk("mem_write", mem_write, exp_strobe && act.w);
        if (exp_strobe) begin
          chk("mem_addr", mem_addr, act.a);
          if (act.w) chk("mem_wdata", mem_wdata, act.d);
        end
        if (exp_done) begin
          if (!act.w) begin
            if (act_id == 0) m_rd0 = act.rd; else m_rd1 = act.rd;
          end
          if (act_id == 0) begin void'(q0.pop_front()); granted0 = 0; end
          else             begin void'(q1.pop_front()); granted1 = 0; end
          act_valid = 0;
        end
        chk("done0", done0, exp_done && act_id == 0);
        chk("done1", done1, exp_done && act_id == 1);
        chk("req0_rdata", req0_rdata, m_rd0);
        chk("req1_rdata", req1_rdata, m_rd1);
        rec0 = req0_read | req0_write;
        rec1 = req1_read | req1_write;
        cyc++;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic set_req(input int n, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [15:0] d);
    if (n == 0) begin req0_read = rd; req0_write = wr; req0_addr = a; req0_wdata = d; end
    else        begin req1_read = rd; req1_write = wr; req1_addr = a; req1_wdata = d; end
  endtask

  task automatic idle_req(input int n);
    set_req(n, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Presents a request and holds it until the done pulse. Once the access
  // has been granted, it can scramble or drop the inputs, which must not
  // affect the access in flight.
  task automatic drive_req(input int n, input bit rd, input bit wr,
                           input logic [15:0] a, input logic [15:0] d, input bit perturb);
    txn_t t;
    bit   got;
    t.w = wr; t.a = a; t.d = d; t.rd = mem_val(a);
    if (n == 0) q0.push_back(t); else q1.push_back(t);
    set_req(n, rd, wr, a, d);
    got = 0;
    for (int k = 0; k < TIMEOUT && !got; k++) begin
      @(posedge clk); #2;
      if ((n == 0) ? done0 : done1) got = 1;
      else if (perturb && ((n == 0) ? granted0 : granted1) && $urandom_range(0, 2) == 0)
        set_req(n, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    end
    chk($sformatf("done%0d_seen", n), got, 1);
  endtask

  task automatic rand_loop(input int n, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int op;
      int gap;
      op = $urandom_range(0, 3);  // 0,1 read; 2 write; 3 both strobes
      drive_req(n, op != 2, op >= 2, 16'($urandom), 16'($urandom), 1'b1);
      gap = $urandom_range(0, 4);
      if (gap != 0) begin
        idle_req(n);
        repeat (gap) begin @(posedge clk); #2; end
      end
    end
    idle_req(n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    idle_req(0); idle_req(1);
    b_req0_read = 1'b0; b_req0_addr = 16'h0000;
    init_model();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_req0_rdata", req0_rdata, 0);
    chk("rst_req1_rdata", req1_rdata, 0);
    chk("rst_b_mem_read", b_mem_read, 0);
    chk("rst_b_done0", b_done0, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    init_model();
    mon_en = 1'b1;

    // Directed read from requester 0.
    drive_req(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
    idle_req(0);
    chk("dir_read_beef", req0_rdata, 16'hBEEF);

    // Directed write from requester 1.
    drive_req(1, 1'b0, 1'b1, 16'h0123, 16'h5A5A, 1'b0);
    idle_req(1);
    chk("dir_write_rdata1_kept", req1_rdata, 16'h0000);

    // Both requesters reading continuously.
    fork
      begin
        for (int i = 0; i < 4; i++) drive_req(0, 1'b1, 1'b0, 16'($urandom), 16'h0000, 1'b0);
        idle_req(0);
      end
      begin
        for (int i = 0; i < 4; i++) drive_req(1, 1'b1, 1'b0, 16'($urandom), 16'h0000, 1'b0);
        idle_req(1);
      end
    join

    // Random traffic on both requesters.
    fork
      rand_loop(0, 30);
      rand_loop(1, 30);
    join

    // Reset during the second access cycle.
    repeat (3) begin @(posedge clk); #2; end
    mon_en = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    set_req(0, 1'b1, 1'b0, 16'h0300, 16'h0000);
    @(posedge clk);  // grant edge
    @(posedge clk);  // first access edge
    #3;
    chk("pre_rst_mem_read", mem_read, 1);
    chk("pre_rst_mem_addr", mem_addr, 16'h0300);
    rst = 1'b1;
    #1;
    chk("async_rst_mem_read", mem_read, 0);
    chk("async_rst_done0", done0, 0);
    chk("async_rst_req0_rdata", req0_rdata, 0);
    chk("async_rst_mem_addr", mem_addr, 0);
    idle_req(0);
    @(posedge clk); #2;
    rst = 1'b0;
    init_model();
    mon_en = 1'b1;
    repeat (6) begin @(posedge clk); #2; end
    chk("post_rst_mem_addr", mem_addr, 0);
    chk("post_rst_mem_wdata", mem_wdata, 0);

    // Traffic again after reset.
    fork
      rand_loop(0, 10);
      rand_loop(1, 10);
    join
    repeat (4) begin @(posedge clk); #2; end
    mon_en = 1'b0;

    // MEM_LATENCY=1 instance: single read.
    b_req0_read = 1'b1; b_req0_addr = 16'h0777;
    @(posedge clk); #2;
    chk("lat1_mem_read_on", b_mem_read, 1);
    chk("lat1_mem_addr", b_mem_addr, 16'h0777);
    chk("lat1_done0_early", b_done0, 0);
    @(posedge clk); #2;
    chk("lat1_mem_read_off", b_mem_read, 0);
    chk("lat1_done0", b_done0, 1);
    chk("lat1_rdata", b_req0_rdata, mem_val(16'h0777));
    b_req0_read = 1'b0;
    @(posedge clk); #2;
    chk("lat1_done0_end", b_done0, 0);
    chk("lat1_done1", b_done1, 0);
    chk("lat1_mem_write", b_mem_write, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
